// File: rtl/apple_soc_pkg.sv
// Shared SoC definitions: loader FSM encodings, UART frame constants and IMEM word geometry.
package apple_soc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } ldr_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam bit UART_LSB_FIRST = 1'b1;
    localparam int IMEM_DW        = 32;
    localparam int BYTES_PER_WORD = IMEM_DW / UART_DATA_BITS;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver working on an already-synchronised rxd; samples at bit centres.
// abort returns the receiver to idle immediately, discarding any byte in flight.
module uart_rx_byte
    import apple_soc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       abort,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    rx_state_t     state, state_nx;
    logic [CW-1:0] clk_cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_nx;
    logic [7:0]    shift, shift_nx;
    logic          rxd_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RX_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rxd_prev <= 1'b1;
        end else begin
            state    <= state_nx;
            clk_cnt  <= cnt_nx;
            bit_idx  <= bit_nx;
            shift    <= shift_nx;
            rxd_prev <= rxd;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = clk_cnt + 1'b1;
        bit_nx     = bit_idx;
        shift_nx   = shift;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_nx = '0;
                if (rxd_prev && !rxd) state_nx = RX_START;
            end
            RX_START: begin
                // A start bit that is no longer low at half-bit was a glitch.
                if (clk_cnt == HALF_CNT) begin
                    cnt_nx   = '0;
                    bit_nx   = '0;
                    state_nx = rxd ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt == FULL_CNT) begin
                    cnt_nx   = '0;
                    shift_nx = {rxd, shift[7:1]};
                    if (bit_idx == LAST_BIT) state_nx = RX_STOP;
                    else                     bit_nx   = bit_idx + 1'b1;
                end
            end
            RX_STOP: begin
                if (clk_cnt == FULL_CNT) begin
                    cnt_nx   = '0;
                    state_nx = RX_IDLE;
                    if (rxd) byte_valid = 1'b1;
                    else     stop_err   = 1'b1;
                end
            end
            default: state_nx = RX_IDLE;
        endcase
        // A byte finishing in the abort cycle is still reported; only the receiver is rearmed.
        if (abort) begin
            state_nx = RX_IDLE;
            cnt_nx   = '0;
        end
    end

    assign byte_data = shift;

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: packs a little-endian UART byte stream into 32-bit IMEM words while holding the CPU.
// Optional feature macro: IMEM_LOADER_CKSUM_EN adds a 32-bit wrapping checksum output 'cksum'.
module imem_uart_loader
    import apple_soc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int IMEM_AW      = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_imem,
    input  logic               uart0_rxd,
    output logic               imem_wr,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [IMEM_DW-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               load_done,
    output logic [IMEM_AW:0]   word_count,
    output logic               frame_err,
    output logic               addr_ovf
`ifdef IMEM_LOADER_CKSUM_EN
    ,
    output logic [IMEM_DW-1:0] cksum
`endif
);

    logic [1:0]         load_sync, rxd_sync;
    logic               load_prev;
    logic               load_s, rxd_s, load_rise, load_fall;
    ldr_state_t         state, state_nx;
    logic [1:0]         byte_cnt, cnt_after;
    logic [IMEM_DW-1:0] lane_buf, word_merged;
    logic               byte_valid, stop_err, rx_abort;
    logic [7:0]         byte_data;
    logic               acc, word_full, flush_go, load_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_sync <= 2'b00;
            rxd_sync  <= 2'b11;
            load_prev <= 1'b0;
        end else begin
            load_sync <= {load_sync[0], load_imem};
            rxd_sync  <= {rxd_sync[0], uart0_rxd};
            load_prev <= load_sync[1];
        end
    end

    assign load_s    = load_sync[1];
    assign rxd_s     = rxd_sync[1];
    assign load_rise = load_s & ~load_prev;
    assign load_fall = ~load_s & load_prev;
    assign rx_abort  = (state != ST_LOAD) | load_fall;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd_s),
        .abort     (rx_abort),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .stop_err  (stop_err)
    );

    always_comb begin
        acc         = (state == ST_LOAD) && byte_valid;
        word_merged = lane_buf;
        if (acc) word_merged[{byte_cnt, 3'b000} +: 8] = byte_data;
        cnt_after   = acc ? byte_cnt + 2'd1 : byte_cnt;
        word_full   = acc && (byte_cnt == 2'(BYTES_PER_WORD - 1));
        load_start  = (state == ST_IDLE) && load_rise;

        state_nx = state;
        case (state)
            ST_IDLE:  if (load_rise) state_nx = ST_LOAD;
            // A byte landing in the same cycle as the falling edge still counts toward the flush.
            ST_LOAD:  if (load_fall) state_nx = (cnt_after != 2'd0) ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        flush_go = (state == ST_LOAD) && (state_nx == ST_FLUSH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            imem_wr    <= 1'b0;
            imem_wdata <= '0;
            imem_addr  <= '0;
            word_count <= '0;
            frame_err  <= 1'b0;
            addr_ovf   <= 1'b0;
            lane_buf   <= '0;
            byte_cnt   <= '0;
        end else begin
            state     <= state_nx;
            cpu_hold  <= (state_nx != ST_IDLE);
            load_done <= (state != ST_IDLE) && (state_nx == ST_IDLE);
            imem_wr   <= word_full | flush_go;
            if (word_full || flush_go) imem_wdata <= word_merged;

            if (load_start || word_full) lane_buf <= '0;
            else if (acc)                lane_buf <= word_merged;
            byte_cnt <= load_start ? 2'd0 : cnt_after;

            if (load_start) begin
                imem_addr  <= '0;
                word_count <= '0;
                frame_err  <= 1'b0;
                addr_ovf   <= 1'b0;
            end else begin
                // Address advances after the write cycle so addr/data stay stable while imem_wr is high.
                if (imem_wr) begin
                    imem_addr  <= imem_addr + 1'b1;
                    word_count <= word_count + 1'b1;
                    if (&imem_addr) addr_ovf <= 1'b1;
                end
                if ((state == ST_LOAD) && stop_err) frame_err <= 1'b1;
            end
        end
    end

`ifdef IMEM_LOADER_CKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          cksum <= '0;
        else if (load_start) cksum <= '0;
        else if (imem_wr)    cksum <= cksum + imem_wdata;
    end
`endif

endmodule
